// File: rtl/scratch_port_arbiter.sv
// Arbitrates the single-port scratch RAM among store, operand-fetch and host requesters,
// and routes pipelined read returns back to the requester that issued each read.
module scratch_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvld,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic                  rd_inflight
);

    logic [3:0]            starve_cnt;
    logic                  host_force;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [RD_LATENCY-1:0] pipe_own;

    // Grants are gated by reset so nothing reaches the RAM while rst is low.
    always_comb begin
        host_force = host_req && (starve_cnt == 4'(STARVE_LIMIT));
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        host_gnt   = 1'b0;
        if (rst) begin
            if (host_force) begin
                host_gnt = 1'b1;
            end else if (wr_req) begin
                wr_gnt = 1'b1;
            end else if (rd_req) begin
                rd_gnt = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
    end

    assign ram_we = wr_gnt | (host_gnt & host_we);
    assign ram_re = rd_gnt | (host_gnt & ~host_we);

    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (wr_gnt) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end else if (rd_gnt) begin
            ram_addr  = rd_addr;
        end else if (host_gnt) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!host_req || host_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Return pipe: owner 0 = operand fetch, owner 1 = host.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= ram_re;
            pipe_own[0] <= host_gnt;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld     <= 1'b0;
            rd_data    <= '0;
            host_rvld  <= 1'b0;
            host_rdata <= '0;
        end else begin
            rd_vld    <= pipe_vld[RD_LATENCY-1] & ~pipe_own[RD_LATENCY-1];
            host_rvld <= pipe_vld[RD_LATENCY-1] & pipe_own[RD_LATENCY-1];
            if (pipe_vld[RD_LATENCY-1] && !pipe_own[RD_LATENCY-1]) begin
                rd_data <= ram_rdata;
            end
            if (pipe_vld[RD_LATENCY-1] && pipe_own[RD_LATENCY-1]) begin
                host_rdata <= ram_rdata;
            end
        end
    end

    assign rd_inflight = |(pipe_vld & ~pipe_own);

endmodule

// File: tb/tb_scratch_port_arbiter.sv
// Self-checking bench for scratch_port_arbiter: a RAM stub, an arbitration/memory model
// feeding return scoreboards, and directed scenarios for reset, hazards, ordering and starvation.
module tb_scratch_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req, host_req, host_we;
    logic [AW-1:0] wr_addr, rd_addr, host_addr;
    logic [DW-1:0] wr_data, host_wdata;
    logic          wr_gnt, rd_gnt, host_gnt, rd_vld, host_rvld;
    logic [DW-1:0] rd_data, host_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, ram_re, rd_inflight;

    scratch_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RD_LATENCY  (LAT),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvld  (host_rvld),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .rd_inflight(rd_inflight)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM stub with RD_LATENCY-cycle read pipe.
    logic          mem_clear;
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] rpipe   [LAT];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        rpipe[0] <= ram_re ? ram_mem[ram_addr] : 32'hBAD0_0000;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[LAT-1];

    // Model: expected grants, program-order memory image, return scoreboards.
    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          rd_q[$];
    exp_t          host_q[$];
    exp_t          ent;
    logic [DW-1:0] mdl_mem [16];
    int            mdl_starve;
    logic          e_force, e_w, e_r, e_h, e_inf;
    int            n_rd_vld = 0;
    int            n_host_rvld = 0;

    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
        end
        if (!rst) begin
            rd_q.delete();
            host_q.delete();
            mdl_starve = 0;
        end else begin
            e_force = host_req && (mdl_starve == LIMIT);
            e_w     = wr_req && !e_force;
            e_r     = rd_req && !wr_req && !e_force;
            e_h     = host_req && (e_force || (!wr_req && !rd_req));
            check("wr_gnt", wr_gnt, e_w);
            check("rd_gnt", rd_gnt, e_r);
            check("host_gnt", host_gnt, e_h);
            check("ram_we", ram_we, e_w || (e_h && host_we));
            check("ram_re", ram_re, e_r || (e_h && !host_we));
            if (e_w) check("ram_wr_drive", {ram_addr, ram_wdata}, {wr_addr, wr_data});
            if (e_r) check("ram_rd_addr", ram_addr, rd_addr);
            if (e_h) check("ram_host_addr", ram_addr, host_addr);
            if (e_h && host_we) check("ram_host_wdata", ram_wdata, host_wdata);

            if (rd_vld) begin
                if (rd_q.size() == 0) begin
                    check("rd_vld_spurious", 1'b1, 1'b0);
                end else begin
                    ent = rd_q.pop_front();
                    check("rd_data", rd_data, ent.data);
                    check("rd_vld_cycle", cyc, ent.due);
                end
            end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
                check("rd_vld_missing", 1'b0, 1'b1);
                void'(rd_q.pop_front());
            end
            if (host_rvld) begin
                if (host_q.size() == 0) begin
                    check("host_rvld_spurious", 1'b1, 1'b0);
                end else begin
                    ent = host_q.pop_front();
                    check("host_rdata", host_rdata, ent.data);
                    check("host_rvld_cycle", cyc, ent.due);
                end
            end else if (host_q.size() != 0 && host_q[0].due <= cyc) begin
                check("host_rvld_missing", 1'b0, 1'b1);
                void'(host_q.pop_front());
            end

            e_inf = 1'b0;
            foreach (rd_q[i]) if (rd_q[i].due - LAT <= cyc && cyc < rd_q[i].due) e_inf = 1'b1;
            check("rd_inflight", rd_inflight, e_inf);

            if (e_r) rd_q.push_back('{data: mdl_mem[rd_addr], due: cyc + LAT + 1});
            if (e_h && !host_we) host_q.push_back('{data: mdl_mem[host_addr], due: cyc + LAT + 1});
            if (e_w) mdl_mem[wr_addr] = wr_data;
            if (e_h && host_we) mdl_mem[host_addr] = host_wdata;
            if (host_req && !e_h) mdl_starve = (mdl_starve < LIMIT) ? mdl_starve + 1 : LIMIT;
            else mdl_starve = 0;
        end
        n_rd_vld    += int'(rd_vld);
        n_host_rvld += int'(host_rvld);
    end

    task automatic wait_vld(input bit host, output int at, output logic [DW-1:0] d);
        at = -1;
        d  = '0;
        for (int k = 0; k < 12 && at < 0; k++) begin
            @(negedge clk);
            if (!host && rd_vld) begin
                at = cyc;
                d  = rd_data;
            end
            if (host && host_rvld) begin
                at = cyc;
                d  = host_rdata;
            end
        end
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        step();
        host_req   = 1'b0;
    endtask

    int            g, at, n0, n1, first, hv, resumed;
    logic [DW-1:0] d, hd, rdd;
    logic          sel;

    initial begin
        rst = 1'b0; mem_clear = 1'b1;
        wr_req = 0; rd_req = 0; host_req = 0; host_we = 0;
        wr_addr = '0; rd_addr = '0; host_addr = '0; wr_data = '0; host_wdata = '0;
        repeat (2) step();
        @(negedge clk);
        check("reset_outputs", {wr_gnt, rd_gnt, rd_data, rd_vld, host_gnt, host_rdata, host_rvld,
                                ram_addr, ram_wdata, ram_we, ram_re, rd_inflight}, '0);
        step();
        rst = 1'b1; mem_clear = 1'b0;

        // 1: reset one cycle after a read grant discards the read.
        step();
        rd_req = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        check("t1_rd_gnt", rd_gnt, 1'b1);
        step();
        rd_req = 1'b0; wr_req = 1'b1; rst = 1'b0;
        @(negedge clk);
        check("t1_outputs_in_reset", {wr_gnt, rd_gnt, rd_data, rd_vld, host_gnt, host_rdata,
              host_rvld, ram_addr, ram_wdata, ram_we, ram_re, rd_inflight}, '0);
        step();
        wr_req = 1'b0; rst = 1'b1; n0 = n_rd_vld; n1 = n_host_rvld;
        repeat (LAT + 3) step();
        check("t1_no_rd_vld", n_rd_vld - n0, 0);
        check("t1_no_host_rvld", n_host_rvld - n1, 0);

        // 2: same-cycle write/read to addr 3; read sees the new value.
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        rd_req = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        check("t2_wr_first", {wr_gnt, rd_gnt}, 2'b10);
        step();
        wr_req = 1'b0;
        @(negedge clk);
        check("t2_rd_second", rd_gnt, 1'b1);
        g = cyc;
        step();
        rd_req = 1'b0;
        wait_vld(1'b0, at, d);
        check("t2_latency", at - g, LAT + 1);
        check("t2_data", d, 32'hDEADBEEF);

        // 3: back-to-back reads of 1,2,3.
        for (int i = 1; i <= 3; i++) host_write(4'(i), 32'hA0 + i);
        step();
        rd_req = 1'b1;
        for (int k = 0; k < LAT + 5; k++) begin
            if (k < 3) rd_addr = 4'(k + 1);
            else rd_req = 1'b0;
            @(negedge clk);
            if (k >= 1 && k <= LAT + 2) check("t3_inflight", rd_inflight, 1'b1);
            check("t3_vld_pattern", rd_vld, (k >= LAT + 1) && (k <= LAT + 3));
            if (rd_vld) check("t3_order", rd_data, 32'hA0 + k - LAT);
            step();
        end

        // 4: starving host read while wr/rd alternate.
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
        wr_addr = 4'd7; wr_data = 32'h7777_0000; rd_addr = 4'd9;
        sel = 1'b0; first = -1; hv = -1; resumed = 0; hd = '0;
        for (int k = 0; k < 12; k++) begin
            wr_req = !sel; rd_req = sel;
            @(negedge clk);
            if (host_gnt && first < 0) first = k;
            if (first >= 0 && k > first && (wr_gnt || rd_gnt)) resumed++;
            if (host_rvld) begin
                hv = k;
                hd = host_rdata;
            end
            if ((!sel && wr_gnt) || (sel && rd_gnt)) sel = !sel;
            step();
            if (first >= 0) host_req = 1'b0;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("t4_host_gnt_cycle", first, 4);
        check("t4_rvld_latency", hv - first, LAT + 1);
        check("t4_rdata", hd, 32'hA2);
        check("t4_resume", resumed, 11 - first);

        // 5: host write then operand read of addr 15.
        repeat (LAT + 2) step();
        n1 = n_host_rvld;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd15; host_wdata = 32'h12345678;
        @(negedge clk);
        check("t5_host_gnt", host_gnt, 1'b1);
        step();
        host_req = 1'b0; rd_req = 1'b1; rd_addr = 4'd15;
        @(negedge clk);
        check("t5_rd_gnt", rd_gnt, 1'b1);
        g = cyc;
        step();
        rd_req = 1'b0;
        wait_vld(1'b0, at, d);
        check("t5_latency", at - g, LAT + 1);
        check("t5_data", d, 32'h12345678);
        repeat (2) step();
        check("t5_no_host_rvld", n_host_rvld - n1, 0);

        // 6: adjacent host read (addr 1) and operand read (addr 2).
        n0 = n_rd_vld; n1 = n_host_rvld; hd = '0; rdd = '0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd1;
        @(negedge clk);
        check("t6_host_gnt", host_gnt, 1'b1);
        step();
        host_req = 1'b0; rd_req = 1'b1; rd_addr = 4'd2;
        @(negedge clk);
        check("t6_rd_gnt", rd_gnt, 1'b1);
        step();
        rd_req = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (host_rvld) hd = host_rdata;
            if (rd_vld) rdd = rd_data;
        end
        step();
        check("t6_host_count", n_host_rvld - n1, 1);
        check("t6_rd_count", n_rd_vld - n0, 1);
        check("t6_host_data", hd, 32'hA1);
        check("t6_rd_data", rdd, 32'hA2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
